// File: rtl/pll_sup_pkg.sv
// Shared types and widths for the PLL lock supervisor.
// Optional feature macro used by the top: PLL_SUP_LOSS_COUNT_EN.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN,
        FAULT
    } sup_state_e;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into a clock domain.
// Both stages clear to 0 on the asynchronous active-high reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state always uses non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, qualifies lock, retries on timeout, releases sys_rst.
// Define PLL_SUP_LOSS_COUNT_EN to add the saturating loss_cnt output.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 32,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int STABLE_CYC       = 1024,
    parameter int HOLD_CYC         = 16,
    parameter int MAX_RETRIES      = 7
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               lock_lost
`ifdef PLL_SUP_LOSS_COUNT_EN
    ,
    output logic [LOSS_W-1:0]  loss_cnt
`endif
);

    localparam int CNT_MAX = max_int(max_int(max_int(RST_PULSE_CYC, LOCK_TIMEOUT_CYC),
                                             max_int(STABLE_CYC, HOLD_CYC)), MAX_RETRIES);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic               lk;
    sup_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_d;
    logic               lost_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_cnt;
        lost_d  = lock_lost;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    retry_d = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
                    // The limit is judged on retries already taken, before this increment.
                    if (MAX_RETRIES != 0 && retry_cnt == RETRY_LIMIT)
                        state_d = FAULT;
                    else
                        state_d = PLL_RST;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lk) begin
                    state_d = PLL_RST;
                    lost_d  = 1'b1;
                end
            end
            FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_cnt <= '0;
            lock_lost <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_cnt <= retry_d;
            lock_lost <= lost_d;
            pll_rst   <= (state_d == PLL_RST) || (state_d == FAULT);
            sys_rst   <= (state_d != RUN);
            ready     <= (state_d == RUN);
            fault     <= (state_d == FAULT);
        end
    end

`ifdef PLL_SUP_LOSS_COUNT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)
            loss_cnt <= '0;
        else if (state_q == RUN && !lk && loss_cnt != '1)
            loss_cnt <= loss_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: cycle-timed vector tables plus hand-written reset sequences.
// Builds with or without PLL_SUP_LOSS_COUNT_EN.
module tb_pll_lock_supervisor;

    logic refclk     = 1'b0;
    logic rst        = 1'b1;
    logic pll_locked = 1'b0;

    logic       a_pll_rst, a_sys_rst, a_ready, a_fault, a_lock_lost;
    logic [3:0] a_retry_cnt;
    logic       b_pll_rst, b_sys_rst, b_ready, b_fault, b_lock_lost;
    logic [3:0] b_retry_cnt;
`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [7:0] a_loss_cnt, b_loss_cnt;
`endif

    // dut: bounded retries; dut_inf: retries forever.
    pll_lock_supervisor #(
        .RST_PULSE_CYC(4), .LOCK_TIMEOUT_CYC(20), .STABLE_CYC(8), .HOLD_CYC(3), .MAX_RETRIES(2)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (a_pll_rst),
        .sys_rst    (a_sys_rst),
        .ready      (a_ready),
        .fault      (a_fault),
        .retry_cnt  (a_retry_cnt),
        .lock_lost  (a_lock_lost)
`ifdef PLL_SUP_LOSS_COUNT_EN
        ,
        .loss_cnt   (a_loss_cnt)
`endif
    );

    pll_lock_supervisor #(
        .RST_PULSE_CYC(4), .LOCK_TIMEOUT_CYC(20), .STABLE_CYC(8), .HOLD_CYC(3), .MAX_RETRIES(0)
    ) dut_inf (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .pll_rst    (b_pll_rst),
        .sys_rst    (b_sys_rst),
        .ready      (b_ready),
        .fault      (b_fault),
        .retry_cnt  (b_retry_cnt),
        .lock_lost  (b_lock_lost)
`ifdef PLL_SUP_LOSS_COUNT_EN
        ,
        .loss_cnt   (b_loss_cnt)
`endif
    );

    always #10 refclk = ~refclk;

    // Packed view: {pll_rst, sys_rst, ready, fault, retry_cnt[3:0], lock_lost}
    logic [8:0] a_out, b_out;
    assign a_out = {a_pll_rst, a_sys_rst, a_ready, a_fault, a_retry_cnt, a_lock_lost};
    assign b_out = {b_pll_rst, b_sys_rst, b_ready, b_fault, b_retry_cnt, b_lock_lost};

    typedef struct {
        int         cyc;   // cycle index after rst release at which to sample
        bit         inst;  // 0 = dut, 1 = dut_inf
        logic       drv;   // pll_locked value driven after sampling
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    string      scen;

    function automatic logic [8:0] o(input logic pr, input logic sr, input logic rd,
                                     input logic ft, input int rc, input logic ll);
        logic [31:0] rcv;
        rcv = rc;
        return {pr, sr, rd, ft, rcv[3:0], ll};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
        cyc++;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic add(input int c, input bit inst, input logic drv, input logic [8:0] e);
        vec_t v;
        v.cyc  = c;
        v.inst = inst;
        v.drv  = drv;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        logic [8:0] act;
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) tick();
            exp_q.push_back(vecs[i].exp);
            act = vecs[i].inst ? b_out : a_out;
            check($sformatf("%s[%0d]@cyc%0d", scen, vecs[i].inst, cyc), {7'd0, act}, {7'd0, exp_q.pop_front()});
            pll_locked = vecs[i].drv;
        end
        vecs.delete();
    endtask

    initial begin
        // Nominal lock: locked at cycle 10, two sync flops, 8 STABLE, 3 HOLD -> RUN at 24.
        scen = "nominal";
        apply_reset();
        add(0,  0, 0, o(1,1,0,0,0,0));
        add(3,  0, 0, o(1,1,0,0,0,0));
        add(4,  0, 0, o(0,1,0,0,0,0));
        add(10, 0, 1, o(0,1,0,0,0,0));
        add(23, 0, 1, o(0,1,0,0,0,0));
        add(24, 0, 1, o(0,0,1,0,0,0));
        add(24, 1, 1, o(0,0,1,0,0,0));
        run_vecs();

        // Permanent no-lock: dut faults on the third timeout, dut_inf keeps retrying.
        scen = "timeout";
        apply_reset();
        add(0,   0, 0, o(1,1,0,0,0,0));
        add(23,  0, 0, o(0,1,0,0,0,0));
        add(24,  0, 0, o(1,1,0,0,1,0));
        add(27,  0, 0, o(1,1,0,0,1,0));
        add(28,  0, 0, o(0,1,0,0,1,0));
        add(47,  0, 0, o(0,1,0,0,1,0));
        add(48,  0, 0, o(1,1,0,0,2,0));
        add(52,  0, 0, o(0,1,0,0,2,0));
        add(71,  0, 0, o(0,1,0,0,2,0));
        add(72,  0, 0, o(1,1,0,1,3,0));
        add(72,  1, 0, o(1,1,0,0,3,0));
        add(120, 1, 0, o(1,1,0,0,5,0));
        add(240, 1, 0, o(1,1,0,0,10,0));
        add(244, 1, 0, o(0,1,0,0,10,0));
        add(480, 1, 0, o(1,1,0,0,15,0));
        add(500, 0, 1, o(1,1,0,1,3,0));
        add(530, 0, 1, o(1,1,0,1,3,0));
        run_vecs();

        // One-cycle dropout inside STABLE: back to WAIT_LOCK, no retry, RUN delayed to 31.
        scen = "unstable";
        apply_reset();
        add(0,  0, 0, o(1,1,0,0,0,0));
        add(10, 0, 1, o(0,1,0,0,0,0));
        add(16, 0, 0, o(0,1,0,0,0,0));
        add(17, 0, 1, o(0,1,0,0,0,0));
        add(19, 0, 1, o(0,1,0,0,0,0));
        add(24, 0, 1, o(0,1,0,0,0,0));
        add(30, 0, 1, o(0,1,0,0,0,0));
        add(31, 0, 1, o(0,0,1,0,0,0));
        run_vecs();

        // Loss of lock in RUN, repulse, relock, RUN again with sticky lock_lost.
        scen = "loss";
        apply_reset();
        add(0,  0, 0, o(1,1,0,0,0,0));
        add(10, 0, 1, o(0,1,0,0,0,0));
        add(24, 0, 1, o(0,0,1,0,0,0));
        add(30, 0, 0, o(0,0,1,0,0,0));
        add(32, 0, 0, o(0,0,1,0,0,0));
        add(33, 0, 0, o(1,1,0,0,0,1));
        add(36, 0, 0, o(1,1,0,0,0,1));
        add(37, 0, 0, o(0,1,0,0,0,1));
        add(40, 0, 1, o(0,1,0,0,0,1));
        add(53, 0, 1, o(0,1,0,0,0,1));
        add(54, 0, 1, o(0,0,1,0,0,1));
        run_vecs();
`ifdef PLL_SUP_LOSS_COUNT_EN
        check("loss_cnt", {8'd0, a_loss_cnt}, 16'd1);
`endif
        // Reset while in RUN must also clear the sticky flag, before the next edge.
        #3 rst = 1'b1;
        #1 check("async_rst_run", {7'd0, a_out}, {7'd0, o(1,1,0,0,0,0)});
`ifdef PLL_SUP_LOSS_COUNT_EN
        check("async_rst_loss_cnt", {8'd0, a_loss_cnt}, 16'd0);
`endif

        // Reset asserted in HOLD: outputs return to reset values asynchronously.
        scen = "hold_rst";
        apply_reset();
        add(0,  0, 0, o(1,1,0,0,0,0));
        add(10, 0, 1, o(0,1,0,0,0,0));
        add(22, 0, 1, o(0,1,0,0,0,0));
        run_vecs();
        #3 rst = 1'b1;
        #1 check("async_rst_hold", {7'd0, a_out}, {7'd0, o(1,1,0,0,0,0)});
        check("async_rst_hold_inf", {7'd0, b_out}, {7'd0, o(1,1,0,0,0,0)});

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Initiator side of the PLL reset/locked handshake.
- Drives the PLL's `rst` input and consumes its asynchronous `locked` output.
- Qualifies lock with a stability window, retries the PLL on timeout, and releases a synchronous system reset only once all clocks are trustworthy.
- Runs on the free-running 50 MHz board reference clock, upstream of every core clock domain.

Parameters:
- RST_PULSE_CYC, 32: refclk cycles `pll_rst` is held high per attempt (min 1).
- LOCK_TIMEOUT_CYC, 50000: cycles to wait for synchronized lock before retrying (1 ms at 50 MHz).
- STABLE_CYC, 1024: consecutive locked cycles required before lock is accepted.
- HOLD_CYC, 16: cycles `sys_rst` stays high after lock is accepted.
- MAX_RETRIES, 7: retries after the first attempt before FAULT; 0 means retry forever.

Ports:
- refclk  in  1  free-running 50 MHz reference; sole clock.
- rst  in  1  asynchronous, active-high master reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- pll_rst  out  1  reset to the PLL.
- sys_rst  out  1  system reset for downstream logic.
- ready  out  1  high in RUN only.
- fault  out  1  high in FAULT only.
- retry_cnt  out  4  attempts made since rst, saturating at 15.
- lock_lost  out  1  sticky: lock dropped while in RUN.

Behaviour:
- Interface (decided): one clock, `refclk`; reset `rst` is asynchronous and active-high.
- Reset values while `rst` is high:
  - state PLL_RST, pll_rst=1, sys_rst=1
  - ready=0, fault=0, retry_cnt=0, lock_lost=0
  - all counters 0
- `pll_locked` passes through a 2-flop synchronizer, reset to 0. `lk` denotes the synchronized value. Response latency to `pll_locked` is 2 cycles plus FSM cycles.
- PLL_RST:
  - pll_rst=1, sys_rst=1.
  - Counts RST_PULSE_CYC cycles, then enters WAIT_LOCK and clears the counter.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If lk=1: enter STABLE.
  - Else if the counter reaches LOCK_TIMEOUT_CYC-1: increment retry_cnt (saturating).
    - If MAX_RETRIES≠0 and retries taken == MAX_RETRIES: enter FAULT.
    - Otherwise: enter PLL_RST.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - If lk=0 on any cycle: return to WAIT_LOCK. The timeout counter restarts; retry_cnt is unchanged.
  - After STABLE_CYC consecutive lk=1 cycles: enter HOLD.
- HOLD:
  - pll_rst=0, sys_rst=1.
  - After HOLD_CYC cycles: enter RUN.
  - If lk drops: enter PLL_RST.
- RUN:
  - sys_rst=0, ready=1.
  - If lk=0: in the same edge set lock_lost=1, assert sys_rst=1 (registered, next cycle), and enter PLL_RST. retry_cnt is not incremented.
- FAULT:
  - pll_rst=1, sys_rst=1, fault=1.
  - Terminal; only `rst` exits.
- All outputs are registered; there are no combinational paths from `pll_locked`.
- A glitch on `pll_locked` shorter than one refclk period may or may not be sampled; either outcome must be handled by the rules above.
- Asserting `rst` mid-operation forces the reset values immediately, asynchronously.
- Counter widths are $clog2 of the largest parameter, plus 1. Terminal comparisons use ==.

Optional Feature:
- Macro: PLL_SUP_LOSS_COUNT_EN.
- When defined:
  - Adds output `loss_cnt`, 8 bits: a saturating count of RUN→PLL_RST lock-loss events.
  - Reset value 0; holds at 255 once reached.
- When undefined:
  - The port is absent; only the sticky `lock_lost` flag is provided.

Decomposition:
- Package `pll_sup_pkg` holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, HOLD, RUN, FAULT)
  - the `retry_cnt` width constant (4)
  - the `loss_cnt` width constant (8)
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer with async active-high reset to 0. Reusable for the core clock domains.

Test Plan:
- Use small parameters (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, HOLD_CYC=3, MAX_RETRIES=2) unless stated.
- Nominal: release rst; pll_locked=1 from cycle 10 → pll_rst high for cycles 0–3; ready=1 and sys_rst=0 at the deterministic cycle (sync+8+3), checked exactly.
- Timeout/fault: pll_locked held at 0 →
  - three pll_rst pulses of 4 cycles, 20-cycle gaps
  - retry_cnt goes 1 then 2
  - fault=1 after the third timeout; pll_rst stays 1.
- Unstable lock: pll_locked drops for 1 cycle at the 5th STABLE cycle → returns to WAIT_LOCK, retry_cnt unchanged, STABLE restarts the 8-cycle count.
- Loss in RUN: drop pll_locked after ready → sys_rst=1 within 4 cycles, lock_lost=1, new pll_rst pulse, then ready again after relock. With PLL_SUP_LOSS_COUNT_EN, loss_cnt=1.
- Mid-operation reset: assert rst during HOLD → all outputs return to reset values asynchronously, before the next refclk edge.
- MAX_RETRIES=0 with pll_locked=0 for 10 timeouts → never FAULT; retry_cnt saturates at 15 in a longer run.
